// File: rtl/mask_share_encoder.sv
// Boolean masking encoder: splits a WIDTH-bit secret into NSHARES XOR shares
// using NSHARES-1 fresh RNG words; share 0 is written last, fully masked.

module mask_share_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module mask_share_encoder #(
  parameter int WIDTH   = 8,
  parameter int NSHARES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         rnd_data,
  input  logic                     rnd_valid,
  output logic                     rnd_ready,
  output logic [NSHARES*WIDTH-1:0] s_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);
  localparam int KW = $clog2(NSHARES);

  typedef enum logic [1:0] {IDLE = 2'd0, GEN = 2'd1, OUT = 2'd2} state_t;

  state_t                          state;
  logic [WIDTH-1:0]                acc;
  logic [KW-1:0]                   k;
  logic                            rnd_fire;
  logic                            last_word;
  logic [NSHARES-1:0]              share_we;
  logic [NSHARES-1:0][WIDTH-1:0]   share_d;
  logic [NSHARES-1:0][WIDTH-1:0]   share_q;

  if (NSHARES < 2) begin : g_bad_param
    $error("mask_share_encoder: NSHARES must be at least 2");
  end

  assign rnd_fire  = rnd_ready & rnd_valid;
  assign last_word = (k == KW'(NSHARES - 1));

  // Share 0 is the only lane that ever sees the accumulator, and only
  // once the last random word has been folded in.
  for (genvar i = 0; i < NSHARES; i++) begin : g_lane
    if (i == 0) begin : g_s0
      assign share_we[i] = rnd_fire & last_word;
      assign share_d[i]  = acc ^ rnd_data;
    end else begin : g_sk
      assign share_we[i] = rnd_fire & (k == KW'(i));
      assign share_d[i]  = rnd_data;
    end
    mask_share_lane #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (share_we[i]),
      .d     (share_d[i]),
      .q     (share_q[i])
    );
  end

  assign s_out = share_q;

  // Handshake outputs are flops updated alongside the state, so nothing
  // on the output side is a combinational decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      k         <= '0;
      in_ready  <= 1'b1;
      rnd_ready <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            acc       <= in_data;
            k         <= KW'(1);
            state     <= GEN;
            in_ready  <= 1'b0;
            rnd_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        GEN: begin
          if (rnd_fire) begin
            acc <= acc ^ rnd_data;
            if (last_word) begin
              k         <= '0;
              state     <= OUT;
              rnd_ready <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        OUT: begin
          // in_ready rises only after the handshake edge, never alongside it.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          rnd_ready <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mask_share_encoder.sv
// Scoreboarded bench for mask_share_encoder: default 8-bit/4-share instance
// plus a 16-bit/2-share instance for the parameter corner.

module tb_mask_share_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0, rnd_data = '0;
  logic        in_valid = 0, rnd_valid = 0, out_ready = 0;
  logic        in_ready, rnd_ready, out_valid, busy;
  logic [31:0] s_out;

  logic [15:0] in_data2 = '0, rnd_data2 = '0;
  logic        in_valid2 = 0, rnd_valid2 = 0, out_ready2 = 0;
  logic        in_ready2, rnd_ready2, out_valid2, busy2;
  logic [31:0] s_out2;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  logic [31:0] sb2[$];

  always #5 clk = ~clk;

  mask_share_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .s_out(s_out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  mask_share_encoder #(.WIDTH(16), .NSHARES(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .rnd_data(rnd_data2), .rnd_valid(rnd_valid2), .rnd_ready(rnd_ready2),
    .s_out(s_out2), .out_valid(out_valid2), .out_ready(out_ready2), .busy(busy2)
  );

  // Scoreboard: every output handshake pops one expected sharing.
  always @(posedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_output got=%h", s_out);
        end else begin
          logic [31:0] e;
          e = sb.pop_front();
          if (s_out !== e) begin
            errors++;
            $display("FAIL sb_shares got=%h exp=%h", s_out, e);
          end
        end
      end
      if (out_valid2 && out_ready2) begin
        checks++;
        if (sb2.size() == 0) begin
          errors++;
          $display("FAIL sb2_unexpected_output got=%h", s_out2);
        end else begin
          logic [31:0] e;
          e = sb2.pop_front();
          if (s_out2 !== e) begin
            errors++;
            $display("FAIL sb2_shares got=%h exp=%h", s_out2, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one secret through accept and all three RNG words, stalling
  // `stall` cycles before the second word; pushes the model's sharing.
  task automatic send(input logic [7:0] x, input logic [7:0] r0, r1, r2,
                      input int stall, output int lat, output bit rr_ok);
    logic [7:0] r[3];
    r = '{r0, r1, r2};
    rr_ok = 1'b1;
    lat = 0;
    in_data = x;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    sb.push_back({r2, r1, r0, x ^ r0 ^ r1 ^ r2});
    tick();
    in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (j == 1) begin
        for (int s = 0; s < stall; s++) begin
          rnd_valid = 1'b0;
          if (!rnd_ready) rr_ok = 1'b0;
          tick();
          lat++;
        end
      end
      rnd_data = r[j];
      rnd_valid = 1'b1;
      if (!rnd_ready) rr_ok = 1'b0;
      tick();
      lat++;
    end
    rnd_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (rnd_ready !== 1'b0) begin errors++; $display("FAIL reset_rnd_ready got=%b exp=0", rnd_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (s_out !== 32'h0) begin errors++; $display("FAIL reset_s_out got=%h exp=0", s_out); end
    if (s_out2 !== 32'h0) begin errors++; $display("FAIL reset_s_out2 got=%h exp=0", s_out2); end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    int lat; bit ok;
    send(8'hA5, 8'h12, 8'h34, 8'h56, 0, lat, ok);
    checks += 4;
    if (lat != 3) begin errors++; $display("FAIL basic_latency got=%0d exp=3", lat); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
    if (s_out !== 32'h563412D5) begin errors++; $display("FAIL basic_shares got=%h exp=563412d5", s_out); end
    if ((s_out[7:0] ^ s_out[15:8] ^ s_out[23:16] ^ s_out[31:24]) !== 8'hA5) begin
      errors++; $display("FAIL basic_xor_recon got=%h exp=a5", s_out[7:0] ^ s_out[15:8] ^ s_out[23:16] ^ s_out[31:24]);
    end
    drain();
  endtask

  task automatic test_rng_stall();
    int lat; bit ok;
    send(8'hA5, 8'h12, 8'h34, 8'h56, 2, lat, ok);
    checks += 3;
    if (lat != 5) begin errors++; $display("FAIL stall_latency got=%0d exp=5", lat); end
    if (ok !== 1'b1) begin errors++; $display("FAIL stall_rnd_ready got=%b exp=1", ok); end
    if (s_out !== 32'h563412D5) begin errors++; $display("FAIL stall_shares got=%h exp=563412d5", s_out); end
    drain();
  endtask

  task automatic test_backpressure();
    int lat; bit ok;
    logic [31:0] held;
    send(8'h5A, 8'hC3, 8'h81, 8'h7E, 0, lat, ok);
    held = s_out;
    rnd_valid = 1'b1;
    rnd_data = 8'hEE;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks += 4;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid c=%0d got=%b exp=1", c, out_valid); end
      if (s_out !== held) begin errors++; $display("FAIL bp_s_out_stable c=%0d got=%h exp=%h", c, s_out, held); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c=%0d got=%b exp=0", c, in_ready); end
      if (rnd_ready !== 1'b0) begin errors++; $display("FAIL bp_rnd_ready c=%0d got=%b exp=0", c, rnd_ready); end
    end
    rnd_valid = 1'b0;
    drain();
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rl[7];
    logic [7:0] xs[2];
    logic [7:0] s0_exp[2];
    int acc_t[2], hs_t[2];
    int na = 0, nh = 0, ri = 0;
    bit f_in, f_r, f_o;
    rl = '{8'h01, 8'h02, 8'h04, 8'h10, 8'h20, 8'h40, 8'h00};
    xs = '{8'h00, 8'hFF};
    s0_exp = '{8'h07, 8'h8F};
    acc_t = '{0, 0};
    hs_t = '{0, 0};
    out_ready = 1'b1;
    rnd_valid = 1'b1;
    for (int c = 0; c < 40 && nh < 2; c++) begin
      rnd_data = rl[ri];
      in_data = xs[na < 2 ? na : 1];
      in_valid = (na < 2);
      f_in = in_valid & in_ready;
      f_r = rnd_valid & rnd_ready;
      f_o = out_valid & out_ready;
      if (f_in) begin
        sb.push_back({rl[3*na+2], rl[3*na+1], rl[3*na], xs[na] ^ rl[3*na] ^ rl[3*na+1] ^ rl[3*na+2]});
        acc_t[na] = c;
        na++;
      end
      if (f_r && ri < 6) ri++;
      if (f_o) begin
        checks++;
        if (s_out[7:0] !== s0_exp[nh]) begin errors++; $display("FAIL b2b_s0 n=%0d got=%h exp=%h", nh, s_out[7:0], s0_exp[nh]); end
        hs_t[nh] = c;
        nh++;
      end
      tick();
    end
    in_valid = 1'b0;
    rnd_valid = 1'b0;
    out_ready = 1'b0;
    checks += 4;
    if (nh != 2) begin errors++; $display("FAIL b2b_outputs got=%0d exp=2", nh); end
    if (na != 2) begin errors++; $display("FAIL b2b_accepts got=%0d exp=2", na); end
    if (acc_t[1] - hs_t[0] != 1) begin errors++; $display("FAIL b2b_reaccept_gap got=%0d exp=1", acc_t[1] - hs_t[0]); end
    if (acc_t[1] - acc_t[0] != 5) begin errors++; $display("FAIL b2b_period got=%0d exp=5", acc_t[1] - acc_t[0]); end
  endtask

  task automatic test_reset_mid_gen();
    int lat; bit ok;
    in_data = 8'h77;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rnd_data = 8'h99;
    rnd_valid = 1'b1;
    tick();
    rnd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
    if (s_out !== 32'h0) begin errors++; $display("FAIL rst_mid_s_out got=%h exp=0", s_out); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    tick();
    rst_n = 1'b1;
    tick();
    send(8'h3C, 8'hAA, 8'h55, 8'h0F, 0, lat, ok);
    checks += 2;
    if (s_out[7:0] !== (8'h3C ^ 8'hAA ^ 8'h55 ^ 8'h0F)) begin
      errors++; $display("FAIL rst_mid_s0 got=%h exp=%h", s_out[7:0], 8'h3C ^ 8'hAA ^ 8'h55 ^ 8'h0F);
    end
    if ((s_out[7:0] ^ s_out[15:8] ^ s_out[23:16] ^ s_out[31:24]) !== 8'h3C) begin
      errors++; $display("FAIL rst_mid_xor_recon got=%h exp=3c", s_out[7:0] ^ s_out[15:8] ^ s_out[23:16] ^ s_out[31:24]);
    end
    drain();
  endtask

  task automatic test_param();
    int lat = 0;
    in_data2 = 16'h1234;
    in_valid2 = 1'b1;
    for (int i = 0; i < 20 && !in_ready2; i++) tick();
    sb2.push_back({16'hFFFF, 16'h1234 ^ 16'hFFFF});
    tick();
    in_valid2 = 1'b0;
    rnd_data2 = 16'hFFFF;
    rnd_valid2 = 1'b1;
    tick();
    lat++;
    rnd_valid2 = 1'b0;
    checks += 2;
    if (out_valid2 !== 1'b1) begin errors++; $display("FAIL param_latency out_valid=%b exp=1 after %0d", out_valid2, lat); end
    if (s_out2 !== 32'hFFFFEDCB) begin errors++; $display("FAIL param_shares got=%h exp=ffffedcb", s_out2); end
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
    checks++;
    if (out_valid2 !== 1'b0) begin errors++; $display("FAIL param_release got=%b exp=0", out_valid2); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rng_stall();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_gen();
    test_param();
    tick(); tick();
    checks += 2;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    if (sb2.size() != 0) begin errors++; $display("FAIL sb2_leftover got=%0d exp=0", sb2.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
